// File: rtl/pulse_channel_pkg.sv
// Shared definitions for the pulse-wave voice: FSM encodings, default widths
// and the note-length sentinel.
package pulse_channel_pkg;

  // FSM encodings kept as plain constants for compatibility with older tools
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PLAYING = 1'b1;

  // Default widths for the channel and its bus
  localparam int DEF_PHASE_WIDTH = 32;
  localparam int DEF_DUTY_BITS   = 3;
  localparam int DEF_OUT_WIDTH   = 9;
  localparam int DEF_LEN_WIDTH   = 8;

  // A note length of zero plays until stopped
  localparam int LEN_UNLIMITED = 0;

endpackage

// File: rtl/pulse_channel_if.sv
// Note handshake from the sequencer plus the sample/status outputs to the mixer.
interface pulse_channel_if
  import pulse_channel_pkg::*;
#(
  parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
  parameter int DUTY_BITS   = DEF_DUTY_BITS,
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int LEN_WIDTH   = DEF_LEN_WIDTH
);
  logic                   i_note_valid;
  logic [PHASE_WIDTH-1:0] i_phase_delta;
  logic [DUTY_BITS-1:0]   i_duty;
  logic [OUT_WIDTH-1:0]   i_amplitude;
  logic [LEN_WIDTH-1:0]   i_length;
  logic                   i_stop;
  logic [OUT_WIDTH-1:0]   o_output;
  logic                   o_frame_pulse;
  logic                   o_busy;

  // Sequencer side: drives notes and stops, observes the channel
  modport master (
    output i_note_valid, i_phase_delta, i_duty, i_amplitude, i_length, i_stop,
    input  o_output, o_frame_pulse, o_busy
  );

  // Channel side
  modport slave (
    input  i_note_valid, i_phase_delta, i_duty, i_amplitude, i_length, i_stop,
    output o_output, o_frame_pulse, o_busy
  );
endinterface

// File: rtl/pulse_phase_accumulator.sv
// Modulo-2^PHASE_WIDTH phase accumulator; o_wrap is the carry out of the
// add that is about to be committed this cycle.
module pulse_phase_accumulator #(
  parameter int PHASE_WIDTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_clear,
  input  logic [PHASE_WIDTH-1:0] i_delta,
  output logic [PHASE_WIDTH-1:0] o_phase,
  output logic                   o_wrap
);
  logic [PHASE_WIDTH-1:0] phase_q;
  logic [PHASE_WIDTH-1:0] phase_d;
  logic [PHASE_WIDTH:0]   sum;

  // Next phase: clear has priority, otherwise advance only while enabled
  always_comb begin
    sum = {1'b0, phase_q} + {1'b0, i_delta};
    if (i_clear) begin
      phase_d = '0;
    end else if (i_enable) begin
      phase_d = sum[PHASE_WIDTH-1:0];
    end else begin
      phase_d = phase_q;
    end
  end

  // Phase register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign o_phase = phase_q;
  assign o_wrap  = i_enable & sum[PHASE_WIDTH];
endmodule

// File: rtl/pulse_channel.sv
// Pulse-wave voice: programmable duty/amplitude, note-length counter, and
// note updates deferred to the next period boundary so the waveform never
// glitches mid-period.
module pulse_channel
  import pulse_channel_pkg::*;
#(
  parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
  parameter int DUTY_BITS   = DEF_DUTY_BITS,
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int LEN_WIDTH   = DEF_LEN_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_reset,
  pulse_channel_if.slave   bus
);
  logic [0:0]             state_q, state_d;
  logic [PHASE_WIDTH-1:0] delta_act_q, delta_act_d;
  logic [DUTY_BITS-1:0]   duty_act_q, duty_act_d;
  logic [OUT_WIDTH-1:0]   amp_act_q, amp_act_d;
  logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
  logic [PHASE_WIDTH-1:0] pend_delta_q, pend_delta_d;
  logic [DUTY_BITS-1:0]   pend_duty_q, pend_duty_d;
  logic [OUT_WIDTH-1:0]   pend_amp_q, pend_amp_d;
  logic [LEN_WIDTH-1:0]   pend_len_q, pend_len_d;
  logic                   pend_valid_q, pend_valid_d;
  logic [OUT_WIDTH-1:0]   output_q, output_d;
  logic                   frame_q, frame_d;
  logic                   busy_q, busy_d;

  logic [PHASE_WIDTH-1:0] phase;
  logic                   wrap;
  logic                   acc_enable;
  logic                   acc_clear;
  logic [DUTY_BITS-1:0]   duty_slot;

  // The phase is zero whenever the channel is (or is about to be) idle, so a
  // new note always starts at the beginning of a period.
  assign acc_enable = (state_q == ST_PLAYING);
  assign acc_clear  = (state_d == ST_IDLE);
  assign duty_slot  = phase[PHASE_WIDTH-1 -: DUTY_BITS];

  pulse_phase_accumulator #(
    .PHASE_WIDTH (PHASE_WIDTH)
  ) u_phase (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_enable (acc_enable),
    .i_clear  (acc_clear),
    .i_delta  (delta_act_q),
    .o_phase  (phase),
    .o_wrap   (wrap)
  );

  // FSM, note registers and length counter; stop overrides everything
  always_comb begin
    state_d      = state_q;
    delta_act_d  = delta_act_q;
    duty_act_d   = duty_act_q;
    amp_act_d    = amp_act_q;
    remaining_d  = remaining_q;
    pend_delta_d = pend_delta_q;
    pend_duty_d  = pend_duty_q;
    pend_amp_d   = pend_amp_q;
    pend_len_d   = pend_len_q;
    pend_valid_d = pend_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_stop) begin
          state_d = ST_IDLE;
        end else if (bus.i_note_valid) begin
          state_d      = ST_PLAYING;
          delta_act_d  = bus.i_phase_delta;
          duty_act_d   = bus.i_duty;
          amp_act_d    = bus.i_amplitude;
          remaining_d  = bus.i_length;
          pend_valid_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PLAYING: begin
        if (bus.i_stop) begin
          state_d      = ST_IDLE;
          pend_valid_d = 1'b0;
        end else if (wrap) begin
          if (bus.i_note_valid) begin
            // A note arriving exactly on the boundary wins over anything queued
            delta_act_d  = bus.i_phase_delta;
            duty_act_d   = bus.i_duty;
            amp_act_d    = bus.i_amplitude;
            remaining_d  = bus.i_length;
            pend_valid_d = 1'b0;
          end else if (pend_valid_q) begin
            delta_act_d  = pend_delta_q;
            duty_act_d   = pend_duty_q;
            amp_act_d    = pend_amp_q;
            remaining_d  = pend_len_q;
            pend_valid_d = 1'b0;
          end else if (remaining_q == LEN_WIDTH'(1)) begin
            state_d = ST_IDLE;
          end else if (remaining_q != LEN_WIDTH'(LEN_UNLIMITED)) begin
            remaining_d = remaining_q - LEN_WIDTH'(1);
          end else begin
            remaining_d = remaining_q;
          end
        end else if (bus.i_note_valid) begin
          // Mid-period note: park it until the boundary; the latest one wins
          pend_delta_d = bus.i_phase_delta;
          pend_duty_d  = bus.i_duty;
          pend_amp_d   = bus.i_amplitude;
          pend_len_d   = bus.i_length;
          pend_valid_d = 1'b1;
        end else begin
          state_d = ST_PLAYING;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        pend_valid_d = 1'b0;
      end
    endcase
  end

  // Output sample, frame strobe and busy flag for the next cycle
  always_comb begin
    if ((state_q == ST_PLAYING) && !bus.i_stop && (duty_slot < duty_act_q)) begin
      output_d = amp_act_q;
    end else begin
      output_d = '0;
    end
    frame_d = wrap;
    busy_d  = (state_d == ST_PLAYING);
  end

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      delta_act_q  <= '0;
      duty_act_q   <= '0;
      amp_act_q    <= '0;
      remaining_q  <= '0;
      pend_delta_q <= '0;
      pend_duty_q  <= '0;
      pend_amp_q   <= '0;
      pend_len_q   <= '0;
      pend_valid_q <= 1'b0;
      output_q     <= '0;
      frame_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      delta_act_q  <= delta_act_d;
      duty_act_q   <= duty_act_d;
      amp_act_q    <= amp_act_d;
      remaining_q  <= remaining_d;
      pend_delta_q <= pend_delta_d;
      pend_duty_q  <= pend_duty_d;
      pend_amp_q   <= pend_amp_d;
      pend_len_q   <= pend_len_d;
      pend_valid_q <= pend_valid_d;
      output_q     <= output_d;
      frame_q      <= frame_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.o_output      = output_q;
  assign bus.o_frame_pulse = frame_q;
  assign bus.o_busy        = busy_q;
endmodule

// File: tb/tb_pulse_channel.sv
// Directed bench for pulse_channel with PHASE_WIDTH=8, DUTY_BITS=2, OUT_WIDTH=9.
// Each table row is one clock: inputs held during the cycle, expected outputs
// are those registered at the rising edge that ends it.
module tb_pulse_channel;
  localparam int PW = 8;
  localparam int DB = 2;
  localparam int OW = 9;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pulse_channel_if #(.PHASE_WIDTH(PW), .DUTY_BITS(DB), .OUT_WIDTH(OW), .LEN_WIDTH(LW)) bus ();

  pulse_channel #(.PHASE_WIDTH(PW), .DUTY_BITS(DB), .OUT_WIDTH(OW), .LEN_WIDTH(LW)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  typedef struct {
    logic          r;
    logic          nv;
    logic [PW-1:0] d;
    logic [DB-1:0] du;
    logic [OW-1:0] a;
    logic [LW-1:0] l;
    logic          s;
    logic [OW-1:0] eo;
    logic          ef;
    logic          eb;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic push(input logic r, input logic nv, input int d, input int du, input int a,
                      input int l, input logic s, input int eo, input logic ef, input logic eb);
    vec_t v;
    v.r = r; v.nv = nv; v.d = PW'(d); v.du = DB'(du); v.a = OW'(a); v.l = LW'(l);
    v.s = s; v.eo = OW'(eo); v.ef = ef; v.eb = eb;
    vecs.push_back(v);
  endtask

  task automatic idle(input int eo, input logic ef, input logic eb);
    push(1'b0, 1'b0, 0, 0, 0, 0, 1'b0, eo, ef, eb);
  endtask

  task automatic note(input int d, input int du, input int a, input int l,
                      input int eo, input logic ef, input logic eb);
    push(1'b0, 1'b1, d, du, a, l, 1'b0, eo, ef, eb);
  endtask

  task automatic stop(input int eo, input logic ef, input logic eb);
    push(1'b0, 1'b0, 0, 0, 0, 0, 1'b1, eo, ef, eb);
  endtask

  // One period at delta=64 from phase 0 with the given high level in each slot
  task automatic period4(input int s0, input int s1, input int s2, input int s3, input logic last_busy);
    idle(s0, 1'b0, 1'b1);
    idle(s1, 1'b0, 1'b1);
    idle(s2, 1'b0, 1'b1);
    idle(s3, 1'b1, last_busy);
  endtask

  task automatic drive(input vec_t v);
    rst               = v.r;
    bus.i_note_valid  = v.nv;
    bus.i_phase_delta = v.d;
    bus.i_duty        = v.du;
    bus.i_amplitude   = v.a;
    bus.i_length      = v.l;
    bus.i_stop        = v.s;
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0d want=%0d", name, idx, act, exp);
    end
  endtask

  initial begin
    int p;
    int exp_out;
    int carry;
    int frames_model;
    int frames_dut;

    // Reset state
    push(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    push(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    idle(0, 1'b0, 1'b0);

    // Basic unlimited note, then stop during a high slot, then stop while idle
    note(64, 1, 200, 0, 0, 1'b0, 1'b1);
    period4(200, 0, 0, 0, 1'b1);
    period4(200, 0, 0, 0, 1'b1);
    stop(0, 1'b0, 1'b0);
    idle(0, 1'b0, 1'b0);
    stop(0, 1'b0, 1'b0);

    // Three-period note: 12 samples, 3 frame pulses, busy drops with the last
    note(64, 2, 100, 3, 0, 1'b0, 1'b1);
    period4(100, 100, 0, 0, 1'b1);
    period4(100, 100, 0, 0, 1'b1);
    period4(100, 100, 0, 0, 1'b0);
    idle(0, 1'b0, 1'b0);
    idle(0, 1'b0, 1'b0);

    // Single-period note at delta=128, max duty
    note(128, 3, 5, 1, 0, 1'b0, 1'b1);
    idle(5, 1'b0, 1'b1);
    idle(5, 1'b1, 1'b0);
    idle(0, 1'b0, 1'b0);

    // Mid-period update takes effect only at the boundary
    note(64, 1, 200, 0, 0, 1'b0, 1'b1);
    idle(200, 1'b0, 1'b1);
    note(64, 3, 50, 0, 0, 1'b0, 1'b1);
    idle(0, 1'b0, 1'b1);
    idle(0, 1'b1, 1'b1);
    period4(50, 50, 50, 0, 1'b1);
    // Two strobes in one period: only the second survives
    note(64, 2, 77, 0, 50, 1'b0, 1'b1);
    note(64, 1, 99, 0, 50, 1'b0, 1'b1);
    idle(50, 1'b0, 1'b1);
    idle(0, 1'b1, 1'b1);
    // Pending note queued, then a strobe on the wrap cycle replaces it
    note(64, 3, 11, 0, 99, 1'b0, 1'b1);
    idle(0, 1'b0, 1'b1);
    idle(0, 1'b0, 1'b1);
    note(64, 2, 33, 0, 0, 1'b1, 1'b1);
    period4(33, 33, 0, 0, 1'b1);
    period4(33, 33, 0, 0, 1'b1);
    idle(33, 1'b0, 1'b1);
    idle(33, 1'b0, 1'b1);
    // Stop together with a note: stop wins, both while playing and while idle
    push(1'b0, 1'b1, 64, 3, 40, 0, 1'b1, 0, 1'b0, 1'b0);
    idle(0, 1'b0, 1'b0);
    push(1'b0, 1'b1, 64, 3, 40, 0, 1'b1, 0, 1'b0, 1'b0);
    idle(0, 1'b0, 1'b0);

    // Stop mid-note, then a new note restarts from phase 0
    note(64, 3, 70, 0, 0, 1'b0, 1'b1);
    idle(70, 1'b0, 1'b1);
    idle(70, 1'b0, 1'b1);
    stop(0, 1'b0, 1'b0);
    idle(0, 1'b0, 1'b0);
    note(64, 1, 80, 0, 0, 1'b0, 1'b1);
    idle(80, 1'b0, 1'b1);
    idle(0, 1'b0, 1'b1);

    // Reset mid-note (phase 128), including reset with a simultaneous note
    push(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    idle(0, 1'b0, 1'b0);
    push(1'b1, 1'b1, 64, 3, 1, 0, 1'b0, 0, 1'b0, 1'b0);
    idle(0, 1'b0, 1'b0);

    // Duty 0: silent but busy
    note(64, 0, 123, 0, 0, 1'b0, 1'b1);
    period4(0, 0, 0, 0, 1'b1);
    period4(0, 0, 0, 0, 1'b1);
    stop(0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      chk("output", i, int'(bus.o_output), int'(vecs[i].eo));
      chk("frame", i, int'(bus.o_frame_pulse), int'(vecs[i].ef));
      chk("busy", i, int'(bus.o_busy), int'(vecs[i].eb));
    end

    // delta=255 over 1000 cycles against a small phase model
    rst = 1'b0; bus.i_stop = 1'b0;
    bus.i_note_valid = 1'b1; bus.i_phase_delta = 8'd255; bus.i_duty = 2'd3;
    bus.i_amplitude = 9'd9; bus.i_length = 8'd0;
    @(posedge clk);
    #1;
    chk("fast_start_busy", 0, int'(bus.o_busy), 1);
    chk("fast_start_out", 0, int'(bus.o_output), 0);
    bus.i_note_valid = 1'b0;
    p = 0;
    frames_model = 0;
    frames_dut = 0;
    for (int c = 0; c < 1000; c++) begin
      exp_out = ((p >> 6) < 3) ? 9 : 0;
      carry = ((p + 255) > 255) ? 1 : 0;
      @(posedge clk);
      #1;
      chk("fast_out", c, int'(bus.o_output), exp_out);
      chk("fast_frame", c, int'(bus.o_frame_pulse), carry);
      frames_model += carry;
      frames_dut += int'(bus.o_frame_pulse);
      p = (p + 255) % 256;
    end
    chk("fast_frame_count", 0, frames_dut, frames_model);
    chk("fast_busy_end", 0, int'(bus.o_busy), 1);

    bus.i_stop = 1'b1;
    @(posedge clk);
    #1;
    bus.i_stop = 1'b0;
    chk("fast_stop_busy", 0, int'(bus.o_busy), 0);
    chk("fast_stop_out", 0, int'(bus.o_output), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
